// File: rtl/keccak_pkg.sv
// Shared Keccak lane constants, state encoding and lane-index helpers for the theta stream.
package keccak_pkg;

  localparam int unsigned NLANE_X = 5;
  localparam int unsigned NLANE_Y = 5;

  typedef enum logic [1:0] {
    StLoad,
    StCalc,
    StDrain
  } theta_state_e;

  // Column to the "left" of x, wrapping modulo 5.
  function automatic int unsigned xm1(input int unsigned x);
    return (x + NLANE_X - 1) % NLANE_X;
  endfunction

  // Column to the "right" of x, wrapping modulo 5.
  function automatic int unsigned xp1(input int unsigned x);
    return (x + 1) % NLANE_X;
  endfunction

  // Rotate the low w bits of lane left by one; bits at or above w come back as zero.
  // Lanes are carried in a 64-bit container so one helper serves every legal width.
  function automatic logic [63:0] rol1(input logic [63:0] lane, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) begin
        r[6'((i + 1) % w)] = lane[6'(i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/theta_plane_stream_d_calc.sv
// Combinational theta D computation: D[x] = C[x-1] ^ ROL(C[x+1], 1) over W-bit lanes.
module theta_d_calc
  import keccak_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic [NLANE_X*W-1:0] i_c,
  output logic [NLANE_X*W-1:0] o_d
);

  // Each D lane mixes its left neighbour with the rotated right neighbour.
  always_comb begin
    o_d = '0;
    for (int unsigned x = 0; x < NLANE_X; x++) begin
      o_d[x*W +: W] = i_c[xm1(x)*W +: W] ^ W'(rol1(64'(i_c[xp1(x)*W +: W]), W));
    end
  end

endmodule

// File: rtl/theta_plane_stream.sv
// Streaming Keccak theta: loads 5 planes while accumulating column parity, computes D once,
// then replays the stored planes with every lane XORed by its column's D value.
module theta_plane_stream
  import keccak_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NLANE_X*W-1:0] in_data,
  input  logic                 in_bypass,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NLANE_X*W-1:0] out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned PW = NLANE_X * W;

  theta_state_e r_state;
  theta_state_e w_state_d;

  logic [2:0]    r_row;
  logic [PW-1:0] r_c;
  logic [PW-1:0] r_d;
  logic          r_bypass;
  logic [PW-1:0] r_plane [NLANE_Y];

  logic [PW-1:0] w_d;
  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_row_last;

  assign w_in_hs    = in_valid & in_ready;
  assign w_out_hs   = out_valid & out_ready;
  assign w_row_last = (r_row == 3'd4);

  theta_d_calc #(
    .W (W)
  ) u_d_calc (
    .i_c (r_c),
    .o_d (w_d)
  );

  // Next-state: LOAD for 5 accepted beats, one CALC cycle, DRAIN for 5 accepted beats.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StLoad:  if (w_in_hs && w_row_last) w_state_d = StCalc;
      StCalc:  w_state_d = StDrain;
      StDrain: if (w_out_hs && w_row_last) w_state_d = StLoad;
      default: w_state_d = StLoad;
    endcase
  end

  // Handshake flags and output beat; out_data is forced to zero whenever nothing is offered.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    unique case (r_state)
      StLoad: in_ready = 1'b1;
      StCalc: busy = 1'b1;
      StDrain: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = w_row_last;
        out_data  = r_plane[r_row] ^ r_d;
      end
      default: ;
    endcase
  end

  // Control state, row counter, column parity, D and bypass flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StLoad;
      r_row    <= 3'd0;
      r_c      <= '0;
      r_d      <= '0;
      r_bypass <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StLoad: begin
          if (w_in_hs) begin
            // Beat 0 restarts the parity so no residue from a previous block survives.
            r_c   <= (r_row == 3'd0) ? in_data : (r_c ^ in_data);
            r_row <= w_row_last ? 3'd0 : (r_row + 3'd1);
            if (r_row == 3'd0) r_bypass <= in_bypass;
          end
        end
        StCalc: r_d <= r_bypass ? '0 : w_d;
        StDrain: begin
          if (w_out_hs) r_row <= w_row_last ? 3'd0 : (r_row + 3'd1);
        end
        default: ;
      endcase
    end
  end

  // Plane storage carries no reset; contents only matter after a full LOAD.
  always_ff @(posedge clk) begin
    if (w_in_hs) r_plane[r_row] <= in_data;
  end

endmodule

// File: tb/tb_theta_plane_stream.sv
// Self-checking bench for theta_plane_stream (W=64 and W=8 instances) with a reference model.
module tb_theta_plane_stream;

  typedef logic [63:0] st_t [25];
  typedef struct {
    logic [319:0] d;
    bit           last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_in_valid, a_in_ready, a_in_bypass;
  logic [319:0] a_in_data, a_out_data;
  logic         a_out_valid, a_out_ready, a_out_last, a_busy;

  logic         b_in_valid, b_in_ready, b_in_bypass;
  logic [39:0]  b_in_data, b_out_data;
  logic         b_out_valid, b_out_ready, b_out_last, b_busy;

  int unsigned total = 0;
  int unsigned bad = 0;
  beat_t exp_q[$];

  bit   rnd_ready = 1'b0;
  bit   man_ready = 1'b1;
  logic r_rand = 1'b1;
  assign a_out_ready = rnd_ready ? r_rand : man_ready;

  theta_plane_stream #(.W(64)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_bypass (a_in_bypass),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_last  (a_out_last),
    .busy      (a_busy)
  );

  theta_plane_stream #(.W(8)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_bypass (b_in_bypass),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_last  (b_out_last),
    .busy      (b_busy)
  );

  always @(posedge clk) begin
    #1;
    r_rand = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s timeout got=none want=event", nm);
  endtask

  function automatic logic [63:0] rol_ref(input logic [63:0] v, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  // Theta straight from its definition: column parities, D, then XOR every lane.
  task automatic theta_ref(input st_t s, input int w, input bit byp, output st_t o);
    logic [63:0] c [5];
    logic [63:0] d [5];
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int y = 0; y < 5; y++) c[x] = c[x] ^ (s[x + 5*y] & mask);
    end
    for (int x = 0; x < 5; x++) d[x] = byp ? 64'd0 : (c[(x + 4) % 5] ^ rol_ref(c[(x + 1) % 5], w));
    for (int i = 0; i < 25; i++) o[i] = (s[i] ^ d[i % 5]) & mask;
  endtask

  function automatic logic [319:0] plane_a(input st_t s, input int y);
    logic [319:0] p;
    for (int x = 0; x < 5; x++) p[x*64 +: 64] = s[x + 5*y];
    return p;
  endfunction

  function automatic logic [39:0] plane_b(input st_t s, input int y);
    logic [39:0] p;
    for (int x = 0; x < 5; x++) p[x*8 +: 8] = s[x + 5*y][7:0];
    return p;
  endfunction

  // One compare process: every offered beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_no_overlap", a_in_ready & a_out_valid, 0);
      if (a_out_valid) begin
        if (exp_q.size() == 0) begin
          timeout("a_extra_beat");
        end else begin
          chk("a_out_data", a_out_data, exp_q[0].d);
          chk("a_out_last", a_out_last, exp_q[0].last);
          chk("a_busy_drain", a_busy, 1);
          if (a_out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("a_data_idle", a_out_data, 0);
        chk("a_last_idle", a_out_last, 0);
      end
    end
  end

  // Send a block to the W=64 instance; later beats carry an inverted bypass that must be ignored.
  task automatic send_block_a(input st_t s, input bit byp, input bit gaps);
    st_t o;
    int  n;
    theta_ref(s, 64, byp, o);
    for (int y = 0; y < 5; y++) exp_q.push_back('{d: plane_a(o, y), last: (y == 4)});
    for (int y = 0; y < 5; y++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          a_in_valid  = 1'b0;
          a_in_data   = {10{$urandom}};
          a_in_bypass = 1'($urandom);
          @(posedge clk);
          #1;
        end
      end
      a_in_valid  = 1'b1;
      a_in_data   = plane_a(s, y);
      a_in_bypass = (y == 0) ? byp : ~byp;
      n = 0;
      while (!a_in_ready && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!a_in_ready) timeout("a_in_ready");
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
    end
  endtask

  task automatic wait_a_idle();
    int n = 0;
    while ((exp_q.size() != 0 || a_busy) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0 || a_busy) timeout("a_drain");
  endtask

  // W=8 instance: send, then read back 5 consecutive beats with out_ready held high.
  task automatic run_block_b(input st_t s, input bit byp);
    st_t o;
    int  n;
    theta_ref(s, 8, byp, o);
    for (int y = 0; y < 5; y++) begin
      b_in_valid  = 1'b1;
      b_in_data   = plane_b(s, y);
      b_in_bypass = (y == 0) ? byp : ~byp;
      n = 0;
      while (!b_in_ready && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!b_out_valid) timeout("b_out_valid");
    for (int y = 0; y < 5; y++) begin
      chk("b_out_data", b_out_data, plane_b(o, y));
      chk("b_out_last", b_out_last, (y == 4));
      @(posedge clk);
      #1;
    end
    chk("b_back_to_load", b_in_ready, 1);
  endtask

  initial begin
    st_t  z, s2, s, o;
    logic [319:0] snap;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_bypass = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_bypass = 1'b0; b_out_ready = 1'b1;
    foreach (z[i]) z[i] = '0;
    s2 = z;
    s2[0] = 64'h1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    rst = 1'b0;

    // Hand-computed pins for the model itself.
    theta_ref(s2, 64, 1'b0, o);
    chk("ref_l00", o[0], 64'h1);
    chk("ref_l10", o[1], 64'h1);
    chk("ref_l40", o[4], 64'h2);
    chk("ref_l13", o[16], 64'h1);
    chk("ref_l20", o[2], 64'h0);
    s = z;
    s[0] = 64'h80;
    theta_ref(s, 8, 1'b0, o);
    chk("ref8_l10", o[1], 64'h80);
    chk("ref8_l40", o[4], 64'h01);
    chk("ref8_l44", o[24], 64'h01);

    // Zero block plus latency of the first output beat.
    send_block_a(z, 1'b0, 1'b0);
    chk("t1_calc_valid", a_out_valid, 0);
    chk("t1_calc_ready", a_in_ready, 0);
    chk("t1_calc_busy", a_busy, 1);
    @(posedge clk);
    #1;
    chk("t1_first_valid", a_out_valid, 1);
    wait_a_idle();

    // Single-bit state, parity cancel and bypass.
    send_block_a(s2, 1'b0, 1'b0);
    wait_a_idle();
    s = z;
    s[2] = 64'hDEADBEEF;
    s[17] = 64'hDEADBEEF;
    send_block_a(s, 1'b0, 1'b0);
    wait_a_idle();
    send_block_a(s2, 1'b1, 1'b0);
    wait_a_idle();

    // Backpressure on the second beat for 7 cycles while an input beat is offered.
    man_ready = 1'b0;
    foreach (s[i]) s[i] = {$urandom, $urandom};
    send_block_a(s, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    man_ready = 1'b1;
    @(posedge clk);
    #1;
    man_ready = 1'b0;
    snap = a_out_data;
    a_in_valid = 1'b1;
    a_in_data = {10{$urandom}};
    repeat (7) begin
      @(posedge clk);
      #1;
      chk("t5_valid_held", a_out_valid, 1);
      chk("t5_data_held", a_out_data, snap);
      chk("t5_in_ready_low", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    man_ready = 1'b1;
    wait_a_idle();
    chk("t5_in_ready_after", a_in_ready, 1);

    // Reset in the middle of DRAIN, then a clean block.
    send_block_a(s, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t6_pre_valid", a_out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("t6_out_valid", a_out_valid, 0);
    chk("t6_in_ready", a_in_ready, 1);
    chk("t6_busy", a_busy, 0);
    send_block_a(s2, 1'b0, 1'b0);
    wait_a_idle();

    // Randomized blocks with random gaps and random backpressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      foreach (s[i]) s[i] = {$urandom, $urandom};
      send_block_a(s, ($urandom_range(0, 3) == 0), 1'b1);
    end
    wait_a_idle();
    rnd_ready = 1'b0;

    // Narrow lanes: rotate wrap and random blocks.
    s = z;
    s[0] = 64'h80;
    run_block_b(s, 1'b0);
    for (int k = 0; k < 4; k++) begin
      foreach (s[i]) s[i] = {56'd0, 8'($urandom)};
      run_block_b(s, (k == 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
